// File: rtl/alu_op_issuer_pkg.sv
// Shared encodings for the ALU front-end issuer: ALU op selects, MIPS funct
// codes, FSM states and the decoded-operation record.
package alu_op_issuer_pkg;

    // ALU op-select encodings understood by the slice chain
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;

    // MIPS R-type funct codes handled by the issuer
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    // Issuer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // How a funct code maps onto the ALU: SLT rides on SUB, MUL on ADD
    typedef struct packed {
        logic [2:0] cntrl;
        logic       cin;
        logic       is_mul;
        logic       is_slt;
        logic       err;
    } decode_t;

endpackage

// File: rtl/alu_op_issuer_funct_decode.sv
// Combinational funct decoder: turns a MIPS funct code into the ALU op
// select, carry-in and the MUL/SLT/unsupported flags used by the issuer.
module alu_op_issuer_funct_decode
    import alu_op_issuer_pkg::*;
(
    input  logic [5:0] funct,
    output decode_t    dec
);

    // Map funct onto ALU controls; anything unrecognised is flagged as an error
    always_comb begin
        dec.cntrl  = ALU_ADD;
        dec.cin    = 1'b0;
        dec.is_mul = 1'b0;
        dec.is_slt = 1'b0;
        dec.err    = 1'b0;
        case (funct)
            FUNCT_ADD: dec.cntrl = ALU_ADD;
            FUNCT_SUB: begin
                dec.cntrl = ALU_SUB;
                dec.cin   = 1'b1;
            end
            FUNCT_XOR: dec.cntrl = ALU_XOR;
            FUNCT_SLT: begin
                dec.cntrl  = ALU_SUB;
                dec.cin    = 1'b1;
                dec.is_slt = 1'b1;
            end
            FUNCT_MUL: dec.is_mul = 1'b1;
            default:   dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// ALU operation issuer: accepts a funct/operand request, sequences the
// external combinational ALU (single pass for ADD/SUB/XOR/SLT, W shift-add
// passes for MUL) and holds the result until the consumer takes it.
module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_funct,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    output logic [2:0]   alu_cntrl,
    input  logic [W-1:0] alu_result,
    input  logic         alu_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_cout,
    output logic         rsp_ovf,
    output logic         rsp_err
);

    localparam int              CW        = $clog2(W) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(W);

    decode_t dec;

    state_e        state_q,     state_d;
    logic          req_ready_q, req_ready_d;
    logic [CW-1:0] step_q,      step_d;
    logic [W-1:0]  opa_q,       opa_d;
    logic [W-1:0]  opb_q,       opb_d;
    logic [2:0]    op_cntrl_q,  op_cntrl_d;
    logic          op_cin_q,    op_cin_d;
    logic          op_mul_q,    op_mul_d;
    logic          op_slt_q,    op_slt_d;
    logic [W-1:0]  alu_a_q,     alu_a_d;
    logic [W-1:0]  alu_b_q,     alu_b_d;
    logic          alu_cin_q,   alu_cin_d;
    logic [2:0]    alu_cntrl_q, alu_cntrl_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_data_q,  rsp_data_d;
    logic          rsp_cout_q,  rsp_cout_d;
    logic          rsp_ovf_q,   rsp_ovf_d;
    logic          rsp_err_q,   rsp_err_d;

    logic [W-1:0]  b_eff;
    logic          ovf;
    logic          lt;
    logic [W-1:0]  mcand_next;
    logic [W-1:0]  mplier_next;

    alu_op_issuer_funct_decode u_decode (
        .funct (req_funct),
        .dec   (dec)
    );

    // Signed overflow of the pass currently on the ALU; the ALU inverts B itself for SUB
    assign b_eff = (alu_cntrl_q == ALU_SUB) ? ~alu_b_q : alu_b_q;
    assign ovf   = (alu_a_q[W-1] == b_eff[W-1]) && (alu_result[W-1] != alu_a_q[W-1]);
    assign lt    = alu_result[W-1] ^ ovf;

    // Multiplicand/multiplier after one shift-add step (opa holds mcand, opb holds mplier)
    assign mcand_next  = opa_q << 1;
    assign mplier_next = opb_q >> 1;

    // Next-state and next-output logic; ALU drive and responses hold unless updated
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_cntrl_d  = op_cntrl_q;
        op_cin_d    = op_cin_q;
        op_mul_d    = op_mul_q;
        op_slt_d    = op_slt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_cntrl_d = alu_cntrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    opa_d      = req_a;
                    opb_d      = req_b;
                    op_cntrl_d = dec.cntrl;
                    op_cin_d   = dec.cin;
                    op_mul_d   = dec.is_mul;
                    op_slt_d   = dec.is_slt;
                    step_d     = '0;
                    if (dec.err) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_cout_d  = 1'b0;
                        rsp_ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (step_q == '0) begin
                    // First pass: put the operation (or MUL step 0 with acc=0) on the ALU
                    alu_cntrl_d = op_cntrl_q;
                    alu_cin_d   = op_cin_q;
                    if (op_mul_q) begin
                        alu_a_d = '0;
                        alu_b_d = opb_q[0] ? opa_q : '0;
                    end else begin
                        alu_a_d = opa_q;
                        alu_b_d = opb_q;
                    end
                    step_d = step_q + CW'(1);
                end else if (op_mul_q) begin
                    // Capture the partial sum, shift, and issue the next step
                    opa_d = mcand_next;
                    opb_d = mplier_next;
                    if (step_q == LAST_STEP) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = alu_result;
                        rsp_cout_d  = 1'b0;
                        rsp_ovf_d   = 1'b0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        alu_a_d = alu_result;
                        alu_b_d = mplier_next[0] ? mcand_next : '0;
                        step_d  = step_q + CW'(1);
                    end
                end else begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    if (op_slt_q) begin
                        rsp_data_d = {{(W-1){1'b0}}, lt};
                        rsp_cout_d = 1'b0;
                        rsp_ovf_d  = 1'b0;
                    end else if (alu_cntrl_q == ALU_XOR) begin
                        rsp_data_d = alu_result;
                        rsp_cout_d = 1'b0;
                        rsp_ovf_d  = 1'b0;
                    end else begin
                        rsp_data_d = alu_result;
                        rsp_cout_d = alu_cout;
                        rsp_ovf_d  = ovf;
                    end
                end
            end

            ST_DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_ovf_d   = 1'b0;
                    rsp_cout_d  = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // All state and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            step_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_cntrl_q  <= ALU_ADD;
            op_cin_q    <= 1'b0;
            op_mul_q    <= 1'b0;
            op_slt_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_cntrl_q <= ALU_ADD;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            step_q      <= step_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_cntrl_q  <= op_cntrl_d;
            op_cin_q    <= op_cin_d;
            op_mul_q    <= op_mul_d;
            op_slt_q    <= op_slt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_cntrl_q <= alu_cntrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_cntrl = alu_cntrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: a behavioural W-bit ALU closes the loop, and a
// transaction-level reference model predicts every response and its timing.
module tb_alu_op_issuer;

   localparam int W = 32;

   localparam logic [5:0] fnAdd = 6'h20;
   localparam logic [5:0] fnSub = 6'h22;
   localparam logic [5:0] fnXor = 6'h26;
   localparam logic [5:0] fnSlt = 6'h2A;
   localparam logic [5:0] fnMul = 6'h18;

   typedef struct {
      logic [W-1:0] data;
      logic         cout;
      logic         ovf;
      logic         err;
      int           edges;
      int           accCyc;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [5:0]   req_funct;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic         alu_cin;
   logic [2:0]   alu_cntrl;
   logic [W-1:0] alu_result;
   logic         alu_cout;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_cout;
   logic         rsp_ovf;
   logic         rsp_err;

   int checks = 0;
   int failures = 0;
   int ncyc = 0;
   int rspCount = 0;
   int lastLat = 0;
   bit firstSeen = 0;
   bit armed = 0;
   bit holdOff = 0;
   logic [W-1:0] lastData;
   logic lastCout, lastOvf, lastErr;
   exp_t expQ[$];
   logic [W:0] aluSum;

   alu_op_issuer #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct  (req_funct),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_cntrl  (alu_cntrl),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf),
      .rsp_err    (rsp_err)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALU: plain W-bit add, add-with-inverted-B, or xor
   always_comb begin
      aluSum = '0;
      case (alu_cntrl)
         3'b000:  aluSum = {1'b0, alu_a} + {1'b0, alu_b} + (W+1)'(alu_cin);
         3'b001:  aluSum = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(alu_cin);
         3'b010:  aluSum = {1'b0, alu_a ^ alu_b};
         default: aluSum = '0;
      endcase
   end

   assign alu_result = aluSum[W-1:0];
   assign alu_cout   = aluSum[W];

   // Consumer: mostly ready, with random stalls, or fully stalled while holdOff is set
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rsp_ready = holdOff ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Single comparison point: counts failures and reports what differed
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference result of one request, straight from the arithmetic meaning of each funct
   function automatic exp_t refModel(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   r;
      longint sa, sb, s;
      longint maxS, minS;
      logic [W:0] wide;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      maxS = (longint'(1) << (W-1)) - 1;
      minS = -(longint'(1) << (W-1));
      r.data = '0; r.cout = 1'b0; r.ovf = 1'b0; r.err = 1'b0; r.edges = 2; r.accCyc = 0;
      case (f)
         fnAdd: begin
            wide   = {1'b0, a} + {1'b0, b};
            r.data = wide[W-1:0];
            r.cout = wide[W];
            s      = sa + sb;
            r.ovf  = (s > maxS) || (s < minS);
         end
         fnSub: begin
            r.data = a - b;
            r.cout = (a >= b);
            s      = sa - sb;
            r.ovf  = (s > maxS) || (s < minS);
         end
         fnXor: r.data = a ^ b;
         fnSlt: r.data = (sa < sb) ? 1 : 0;
         fnMul: begin
            r.data  = a * b;
            r.edges = W + 1;
         end
         default: begin
            r.err   = 1'b1;
            r.edges = 0;
         end
      endcase
      return r;
   endfunction

   // Random operand with a bias towards sign/overflow corners
   function automatic logic [W-1:0] randOperand();
      logic [W-1:0] corners[5];
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   // Every negedge: predict req_ready/rsp_valid/rsp_* from the outstanding request and record handshakes
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (armed && rst_n) begin
            ncyc++;
            if (expQ.size() == 0) begin
               checkOutput("idle_rsp_valid", rsp_valid, 1'b0);
               checkOutput("idle_req_ready", req_ready, 1'b1);
            end else begin
               e = expQ[0];
               checkOutput("busy_req_ready", req_ready, 1'b0);
               if (ncyc < e.accCyc + 1 + e.edges) begin
                  checkOutput("early_rsp_valid", rsp_valid, 1'b0);
               end else begin
                  checkOutput("rsp_valid", rsp_valid, 1'b1);
                  checkOutput("rsp_data", rsp_data, e.data);
                  checkOutput("rsp_cout", rsp_cout, e.cout);
                  checkOutput("rsp_ovf", rsp_ovf, e.ovf);
                  checkOutput("rsp_err", rsp_err, e.err);
                  if (rsp_valid && !firstSeen) begin
                     firstSeen = 1'b1;
                     lastLat   = ncyc - e.accCyc - 1;
                  end
                  if (rsp_valid && rsp_ready) begin
                     lastData = rsp_data;
                     lastCout = rsp_cout;
                     lastOvf  = rsp_ovf;
                     lastErr  = rsp_err;
                     rspCount++;
                     void'(expQ.pop_front());
                  end
               end
            end
            if (req_valid && req_ready) begin
               e        = refModel(req_funct, req_a, req_b);
               e.accCyc = ncyc;
               expQ.push_back(e);
               firstSeen = 1'b0;
            end
         end
      end
   end

   // Present one request once the issuer is ready; held for exactly one accepting edge
   task automatic applyStimulus(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      int waitCyc = 0;
      @(posedge clk);
      #1;
      while (!req_ready && waitCyc < 400) begin
         @(posedge clk);
         #1;
         waitCyc++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_timeout", req_ready, 1'b1);
      end else begin
         req_valid = 1'b1;
         req_funct = f;
         req_a     = a;
         req_b     = b;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         req_funct = 6'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
      end
   endtask

   // Bounded wait for the response after the one counted in startCount
   task automatic waitResponse(input int startCount);
      int n = 0;
      while (rspCount == startCount && n < 200) begin
         @(posedge clk);
         n++;
      end
      checkOutput("rsp_timeout", 64'(rspCount != startCount), 64'd1);
   endtask

   // One directed request with hand-computed expectations; expLat < 0 skips the latency pin
   task automatic runDirected(input string name, input logic [5:0] f, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] expData, input logic expCout,
                              input logic expOvf, input logic expErr, input int expLat);
      int startCount;
      startCount = rspCount;
      applyStimulus(f, a, b);
      waitResponse(startCount);
      checkOutput({name, "_data"}, lastData, expData);
      checkOutput({name, "_cout"}, lastCout, expCout);
      checkOutput({name, "_ovf"}, lastOvf, expOvf);
      checkOutput({name, "_err"}, lastErr, expErr);
      if (expLat >= 0) checkOutput({name, "_lat"}, 64'(lastLat), 64'(expLat));
   endtask

   // Hold reset, check the reset state, then release and arm the compare process
   task automatic doReset();
      armed   = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", req_ready, 1'b0);
      checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
      checkOutput("reset_alu_cntrl", alu_cntrl, 3'b000);
      checkOutput("reset_alu_a", alu_a, '0);
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      armed = 1'b1;
   endtask

   // Watchdog so the run always ends even if the design wedges
   initial begin
      #500_000;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: pin the model, directed cases, backpressure, mid-op reset, random traffic
   initial begin
      exp_t tmp;
      int startCount;
      logic [5:0] f;
      req_valid = 1'b0;
      req_funct = '0;
      req_a     = '0;
      req_b     = '0;

      tmp = refModel(fnSlt, 32'h7FFF_FFFF, 32'h8000_0000);
      checkOutput("model_slt_ovf", tmp.data, 32'd0);
      tmp = refModel(fnMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("model_mul_wrap", tmp.data, 32'd1);
      tmp = refModel(fnAdd, 32'h7FFF_FFFF, 32'd1);
      checkOutput("model_add_ovf", tmp.ovf, 1'b1);

      doReset();

      runDirected("add5_7",   fnAdd, 32'd5,          32'd7,          32'd12,          1'b0, 1'b0, 1'b0, 2);
      runDirected("sub3_5",   fnSub, 32'd3,          32'd5,          32'hFFFF_FFFE,   1'b0, 1'b0, 1'b0, 2);
      runDirected("add_ovf",  fnAdd, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,   1'b0, 1'b1, 1'b0, 2);
      runDirected("slt_m1_1", fnSlt, 32'hFFFF_FFFF,  32'd1,          32'd1,           1'b0, 1'b0, 1'b0, 2);
      runDirected("slt_ovf",  fnSlt, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,           1'b0, 1'b0, 1'b0, 2);
      runDirected("slt_eq",   fnSlt, 32'd4,          32'd4,          32'd0,           1'b0, 1'b0, 1'b0, 2);
      runDirected("xor",      fnXor, 32'hF0F0_1234,  32'h0FF0_4321,  32'hFF00_5115,   1'b0, 1'b0, 1'b0, 2);
      runDirected("mul_ffff", fnMul, 32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF,   1'b0, 1'b0, 1'b0, 33);
      runDirected("mul_wrap", fnMul, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,           1'b0, 1'b0, 1'b0, 33);

      // Unsupported funct under a 10-cycle stall: the compare process checks stability each cycle
      holdOff = 1'b1;
      startCount = rspCount;
      applyStimulus(6'h00, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("bp_req_ready", req_ready, 1'b0);
      checkOutput("bp_rsp_err", rsp_err, 1'b1);
      checkOutput("bp_rsp_data", rsp_data, '0);
      holdOff = 1'b0;
      waitResponse(startCount);
      checkOutput("bad_err", lastErr, 1'b1);
      checkOutput("bad_data", lastData, '0);

      // Reset in the middle of a multiply: response must vanish and never appear
      startCount = rspCount;
      applyStimulus(fnMul, 32'h0001_2345, 32'h0006_789A);
      repeat (10) @(posedge clk);
      #3;
      armed = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
      checkOutput("midrst_req_ready", req_ready, 1'b0);
      checkOutput("midrst_alu_cntrl", alu_cntrl, 3'b000);
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      armed = 1'b1;
      repeat (40) @(posedge clk);
      checkOutput("midrst_no_rsp", 64'(rspCount), 64'(startCount));
      runDirected("add1_1", fnAdd, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 2);

      // Random traffic, checked cycle by cycle against the reference model
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 5))
            0: f = fnAdd;
            1: f = fnSub;
            2: f = fnXor;
            3: f = fnSlt;
            4: f = fnMul;
            default: begin
               f = 6'($urandom_range(0, 63));
               if (f == fnAdd || f == fnSub || f == fnXor || f == fnSlt || f == fnMul) f = 6'h3F;
            end
         endcase
         applyStimulus(f, randOperand(), randOperand());
      end
      begin
         int n = 0;
         while (expQ.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
         end
         checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
      end
      repeat (3) @(posedge clk);

      $display("[TB] done after %0d responses", rspCount);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
